sqrt_range_reduce: RTL and testbench
====================================

Name: sqrt_range_reduce

Overview:
- Upstream range-reduction stage for the piecewise-linear square-root evaluator.
- Takes an unsigned fixed-point operand e (UQ7.24, e.g. -2ln(u) from the log stage) and normalizes it via leading-zero detection.
- Emits exponent field oExp_f and mantissa oX_f in exactly the format the sqrt stage consumes: oExp_f[0] selects the table; oX_f[25:16] is the interpolation input.
- 3-stage pipeline, valid-qualified, with global clock enable.

Parameters:
- IN_WIDTH, 31, operand width (UQ7.24); only the default is supported, checked by an elaboration-time assertion.
- IN_FRAC, 24, operand fractional bits.
- EXP_WIDTH, 6, width of oExp_f.
- MANT_WIDTH, 26, width of oX_f (UQ2.24).

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iCe  input  1  pipeline clock enable; low = every stage holds.
- iValid  input  1  iE valid this cycle.
- iE  input  31  operand, UQ7.24.
- oValid  output  1  outputs valid.
- oExp_f  output  6  exponent field; bit0=1 means mantissa in [1,2), bit0=0 means [2,4).
- oX_f  output  26  mantissa, UQ2.24.
- oZero  output  1  operand was zero.

Behaviour:
- Reset (async assert, sync release): all stage registers and outputs go to 0 (oValid=0, oExp_f=0, oX_f=0, oZero=0). In-flight data is discarded; there is no partial completion.
- Pipeline (iCe=1):
  - S1 registers iE and iValid.
  - S2 computes lz = leading zeros of e (0..31) and registers e, lz, zero = (e==0), valid.
  - S3 computes n = e << lz (31 bits, n[30]=1) and p = 30 - lz (MSB position), then registers outputs.
- Latency: exactly 3 enabled cycles, iValid to oValid. Throughput: 1 sample per cycle. No backpressure.
- iCe=0: no register updates in any stage, oValid included. Outputs remain stable. iValid is ignored that cycle.
- Formatting (S3):
  - oExp_f = p + 1 (range 1..31).
  - p even: oX_f = {1'b0, n[30:6]}, value in [1,2), oExp_f[0]=1.
  - p odd: oX_f = n[30:5], value in [2,4), oExp_f[0]=0.
  - Discarded low bits are truncated.
- Contract with downstream: e = oX_f/2^24 * 2^(2k), where k = floor((oExp_f - 25)/2). The reconstruct stage shifts sqrt(oX_f) by k.
- Zero operand: oZero=1, oExp_f=0, oX_f=0, oValid follows iValid normally.
- Data registers may capture while iValid=0 (don't-care). oValid is the sole qualifier. Each stage's valid register is updated every enabled cycle.
- Simultaneous reset and iCe/iValid: reset wins.

Optional Feature:
- SQRT_RR_ROUND_EN defined:
  - S3 rounds to nearest, adding the first discarded bit (n[5] for even p, n[4] for odd p).
  - On mantissa overflow the result saturates to 0x1FFFFFF (even p) or 0x3FFFFFF (odd p); oExp_f is unchanged.
- Undefined: pure truncation; no extra logic.

Decomposition:
- Package sqrt_pkg holds:
  - IN_WIDTH, IN_FRAC, EXP_WIDTH, MANT_WIDTH, EXP_BIAS=25;
  - the ADDR_WIDTH=6 table-index constant shared with the sqrt stage.
- One sub-module, lzd31: purely combinational 31-bit leading-zero counter. Output is a 5-bit count plus an all-zero flag. Built as a two-level tree of 8-bit groups. Instantiated in S2.

Test Plan:
- iE=0x1000000 (1.0), iValid=1, iCe=1 -> 3 cycles later oValid=1, oExp_f=25, oX_f=0x1000000, oZero=0.
- iE=0x2000000 (2.0) -> oExp_f=26, oX_f=0x2000000.
- iE=0x7FFFFFFF:
  - without SQRT_RR_ROUND_EN -> oExp_f=31, oX_f=0x1FFFFFF;
  - with it -> saturated oX_f=0x1FFFFFF.
- iE=0x0000001 -> oExp_f=1, oX_f=0x1000000. iE=0 -> oZero=1, oExp_f=0, oX_f=0.
- Back-to-back stream 0x1000000, 0x3000000, 0x0800000 with iCe low for 2 cycles mid-stream -> outputs appear in order, held during the stall, and each result is present exactly once while iCe=1.
- iRst_n pulsed low with 2 samples in flight -> all outputs 0 immediately (async). After release, oValid stays 0 until a new sample completes 3 cycles later.

Source files
------------

// File: rtl/sqrt_range_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_pkg
// Description : Shared constants, stage-2 payload type and an 8-bit
//               leading-zero helper for the sqrt range-reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

  localparam int IN_WIDTH   = 31;  // operand width, UQ7.24
  localparam int IN_FRAC    = 24;  // operand fractional bits
  localparam int EXP_WIDTH  = 6;   // exponent field width
  localparam int MANT_WIDTH = 26;  // mantissa width, UQ2.24
  localparam int EXP_BIAS   = 25;  // exponent field value of an operand in [1,2)
  localparam int ADDR_WIDTH = 6;   // table-index width shared with the sqrt stage
  localparam int LZ_WIDTH   = 5;   // leading-zero count width (0..31)

  // Payload held between the leading-zero stage and the formatting stage.
  typedef struct packed {
    logic                valid;
    logic                zero;
    logic [LZ_WIDTH-1:0] lz;
    logic [IN_WIDTH-1:0] e;
  } s2_t;

  // Leading zeros of an 8-bit group; result is meaningless for v == 0,
  // callers qualify it with their own all-zero flag.
  function automatic logic [2:0] lzc8(input logic [7:0] v);
    logic [2:0] cnt;
    logic       found;
    cnt   = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      cnt   = cnt + 3'd1;
      end
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_range_reduce_if.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_range_reduce_if
// Description : Operand-in / normalized-result-out bundle of the sqrt
//               range-reduction stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface sqrt_range_reduce_if;
  import sqrt_pkg::*;

  logic                  iValid;
  logic [IN_WIDTH-1:0]   iE;
  logic                  oValid;
  logic [EXP_WIDTH-1:0]  oExp_f;
  logic [MANT_WIDTH-1:0] oX_f;
  logic                  oZero;

  // Upstream side: supplies operands, observes results.
  modport master (
    output iValid, iE,
    input  oValid, oExp_f, oX_f, oZero
  );

  // Range-reduction stage side.
  modport slave (
    input  iValid, iE,
    output oValid, oExp_f, oX_f, oZero
  );

endinterface
`default_nettype wire

// File: rtl/sqrt_range_reduce_lzd31.sv
`default_nettype none
// ============================================================================
// Module      : lzd31
// Description : Combinational 31-bit leading-zero counter, two-level tree of
//               8-bit groups. The operand is padded with a trailing 1 so the
//               32-bit count saturates at 31 for an all-zero operand.
// Revision    : 1.0 - initial release
// ============================================================================
module lzd31
  import sqrt_pkg::*;
(
  input  wire logic [30:0] a_i,
  output logic      [4:0]  cnt_o,
  output logic             zero_o
);

  logic [31:0] pad_w;
  logic [3:0]  grp_zero_w;
  logic [2:0]  grp_cnt_w [4];

  assign pad_w  = {a_i, 1'b1};
  assign zero_o = ~|a_i;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_grp
      assign grp_zero_w[g] = ~|pad_w[8*g+7 -: 8];
      assign grp_cnt_w[g]  = lzc8(pad_w[8*g+7 -: 8]);
    end
  endgenerate

  // Second level: first non-empty group from the MSB end supplies the count.
  // Group 0 always holds the pad bit, so it terminates the search.
  always_comb begin
    cnt_o = {2'd3, grp_cnt_w[0]};
    if (!grp_zero_w[3])      cnt_o = {2'd0, grp_cnt_w[3]};
    else if (!grp_zero_w[2]) cnt_o = {2'd1, grp_cnt_w[2]};
    else if (!grp_zero_w[1]) cnt_o = {2'd2, grp_cnt_w[1]};
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_range_reduce.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_range_reduce
// Description : 3-stage range reduction for the piecewise-linear sqrt.
//               Normalizes a UQ7.24 operand to exponent field + UQ2.24
//               mantissa so that e = oX_f/2^24 * 2^(2k),
//               k = floor((oExp_f - 25)/2).
//               Optional macro SQRT_RR_ROUND_EN: round-to-nearest with
//               saturation instead of truncation.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_range_reduce #(
  parameter int IN_WIDTH   = sqrt_pkg::IN_WIDTH,
  parameter int IN_FRAC    = sqrt_pkg::IN_FRAC,
  parameter int EXP_WIDTH  = sqrt_pkg::EXP_WIDTH,
  parameter int MANT_WIDTH = sqrt_pkg::MANT_WIDTH
) (
  input  wire logic           iClk,
  input  wire logic           iRst_n,
  input  wire logic           iCe,
  sqrt_range_reduce_if.slave  bus
);
  import sqrt_pkg::*;

  generate
    if (IN_WIDTH != 31 || IN_FRAC != 24 || EXP_WIDTH != 6 || MANT_WIDTH != 26) begin : g_bad_param
      $error("sqrt_range_reduce supports only IN_WIDTH=31, IN_FRAC=24, EXP_WIDTH=6, MANT_WIDTH=26");
    end
  endgenerate

  // ---------------- S1: operand capture ----------------
  logic        s1_valid_q;
  logic [30:0] s1_e_q;

  // S1 register: capture operand and its valid flag.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid_q <= 1'b0;
      s1_e_q     <= '0;
    end else if (iCe) begin
      s1_valid_q <= bus.iValid;
      s1_e_q     <= bus.iE;
    end
  end

  // ---------------- S2: leading-zero detection ----------------
  logic [4:0] lzd_cnt;
  logic       lzd_zero;
  s2_t        s2_d;
  s2_t        s2_q;

  lzd31 u_lzd (
    .a_i    (s1_e_q),
    .cnt_o  (lzd_cnt),
    .zero_o (lzd_zero)
  );

  // S2 next state: operand plus its leading-zero count and zero flag.
  always_comb begin
    s2_d.valid = s1_valid_q;
    s2_d.zero  = lzd_zero;
    s2_d.lz    = lzd_cnt;
    s2_d.e     = s1_e_q;
  end

  // S2 register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)  s2_q <= '0;
    else if (iCe) s2_q <= s2_d;
  end

  // ---------------- S3: normalize and format ----------------
  logic [30:0] norm_d;
  logic [4:0]  msb_d;
  logic [25:0] mant_d;
  logic        valid_d;
  logic        zero_d;
  logic [5:0]  exp_d;
  logic [25:0] x_d;
`ifdef SQRT_RR_ROUND_EN
  logic [25:0] rnd_even_d;
  logic [26:0] rnd_odd_d;
`endif

  // S3 next state: shift MSB to bit 30, pick a [1,2) or [2,4) mantissa by
  // MSB parity so the exponent stays even-aligned for the sqrt tables.
  always_comb begin
    norm_d  = s2_q.e << s2_q.lz;
    msb_d   = 5'd30 - s2_q.lz;
`ifdef SQRT_RR_ROUND_EN
    rnd_even_d = {1'b0, norm_d[30:6]} + {25'd0, norm_d[5]};
    rnd_odd_d  = {1'b0, norm_d[30:5]} + {26'd0, norm_d[4]};
    if (!msb_d[0]) mant_d = rnd_even_d[25] ? 26'h1FF_FFFF : {1'b0, rnd_even_d[24:0]};
    else           mant_d = rnd_odd_d[26]  ? 26'h3FF_FFFF : rnd_odd_d[25:0];
`else
    if (!msb_d[0]) mant_d = {1'b0, norm_d[30:6]};
    else           mant_d = norm_d[30:5];
`endif
    valid_d = s2_q.valid;
    zero_d  = s2_q.zero;
    exp_d   = {1'b0, msb_d} + 6'd1;
    x_d     = mant_d;
    if (s2_q.zero) begin
      exp_d = '0;
      x_d   = '0;
    end
  end

  // Bits below the first discarded (rounding) bit never reach the output.
`ifdef SQRT_RR_ROUND_EN
  logic unused_norm_bits;
  assign unused_norm_bits = ^norm_d[3:0];
`else
  logic unused_norm_bits;
  assign unused_norm_bits = ^norm_d[4:0];
`endif

  logic       out_valid_q;
  logic       out_zero_q;
  logic [5:0] out_exp_q;
  logic [25:0] out_x_q;

  // S3 register: output stage.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_exp_q   <= '0;
      out_x_q     <= '0;
    end else if (iCe) begin
      out_valid_q <= valid_d;
      out_zero_q  <= zero_d;
      out_exp_q   <= exp_d;
      out_x_q     <= x_d;
    end
  end

  assign bus.oValid = out_valid_q;
  assign bus.oZero  = out_zero_q;
  assign bus.oExp_f = out_exp_q;
  assign bus.oX_f   = out_x_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_range_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_range_reduce
// Description : Self-checking bench for sqrt_range_reduce: arithmetic model
//               of the normalization with a cycle-level latency tracker,
//               plus hand-computed literal vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_range_reduce;
  import sqrt_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ce    = 1'b0;

  always #5 clk = ~clk;

  sqrt_range_reduce_if bus ();

  sqrt_range_reduce dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .iCe    (ce),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Result {zero, exp, mantissa} from plain arithmetic on the operand value.
  function automatic logic [32:0] model(input logic [30:0] e);
    longint unsigned num, r, mx;
    int p, sc;
    if (e == 31'd0) return {1'b1, 6'd0, 26'd0};
    p = 0;
    for (int i = 0; i < 31; i++) if (e[i]) p = i;
    num = {33'd0, e};
    sc  = (p % 2 == 0) ? 24 : 25;      // mantissa integer bit position
`ifdef SQRT_RR_ROUND_EN
    r  = (num << (sc + 1)) >> p;
    r  = (r + 64'd1) >> 1;
    mx = (64'd1 << (sc + 1)) - 64'd1;
    if (r > mx) r = mx;
`else
    r  = (num << sc) >> p;
    mx = 64'd0;
`endif
    return {1'b0, 6'(p + 1), r[25:0]};
  endfunction

  // Latency tracker: an operand reaches the outputs after 3 enabled edges.
  logic        mv [3] = '{default: 1'b0};
  logic [30:0] me [3] = '{default: 31'd0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv[0] <= 1'b0; mv[1] <= 1'b0; mv[2] <= 1'b0;
    end else if (ce) begin
      mv[0] <= bus.iValid; me[0] <= bus.iE;
      mv[1] <= mv[0];      me[1] <= me[0];
      mv[2] <= mv[1];      me[2] <= me[1];
    end
  end

  logic [25:0] got_q [$];

  // Compare process: outputs vs model every cycle, away from the active edge.
  always @(negedge clk) begin : p_cmp
    logic [32:0] m;
    if (!rst_n) begin
      chk("rst_oValid", {31'd0, bus.oValid}, 32'd0);
      chk("rst_oX_f",   {6'd0, bus.oX_f},    32'd0);
    end else begin
      m = model(me[2]);
      chk("oValid", {31'd0, bus.oValid}, {31'd0, mv[2]});
      if (mv[2]) begin
        chk("oZero",  {31'd0, bus.oZero},  {31'd0, m[32]});
        chk("oExp_f", {26'd0, bus.oExp_f}, {26'd0, m[31:26]});
        chk("oX_f",   {6'd0, bus.oX_f},    {6'd0, m[25:0]});
      end
      if (ce && bus.oValid) got_q.push_back(bus.oX_f);
    end
  end

  // One operand, literal expectations, exact 3-cycle latency, single-cycle valid.
  task automatic lit(input logic [30:0] e, input logic [5:0] ex, input logic [25:0] x,
                     input logic z);
    @(posedge clk); #1 bus.iValid = 1'b1; bus.iE = e;
    @(posedge clk); #1 bus.iValid = 1'b0; bus.iE = 31'($urandom);
    @(posedge clk);
    @(negedge clk); chk("lit_early_valid", {31'd0, bus.oValid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lit_valid", {31'd0, bus.oValid}, 32'd1);
    chk("lit_exp",   {26'd0, bus.oExp_f}, {26'd0, ex});
    chk("lit_x",     {6'd0, bus.oX_f},    {6'd0, x});
    chk("lit_zero",  {31'd0, bus.oZero},  {31'd0, z});
    @(posedge clk);
    @(negedge clk); chk("lit_valid_once", {31'd0, bus.oValid}, 32'd0);
  endtask

  logic [30:0] vec [8] = '{31'h1234567, 31'h5555555, 31'h7FFFFFC0, 31'h00000FF,
                           31'h2AAAAAAB, 31'h0000002, 31'h4000000, 31'h0000000};
  logic [25:0] stall_exp [3] = '{26'h1000000, 26'h3000000, 26'h2000000};

  initial begin
    bus.iValid = 1'b0;
    bus.iE     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; ce = 1'b1;

    // Literal vectors.
    lit(31'h1000000,  6'd25, 26'h1000000, 1'b0);   // 1.0
    lit(31'h2000000,  6'd26, 26'h2000000, 1'b0);   // 2.0
    lit(31'h7FFFFFFF, 6'd31, 26'h1FFFFFF, 1'b0);   // max, truncated or saturated
    lit(31'h0000001,  6'd1,  26'h1000000, 1'b0);   // smallest nonzero
    lit(31'h0000000,  6'd0,  26'h0000000, 1'b1);   // zero operand
    lit(31'h0000003,  6'd2,  26'h3000000, 1'b0);   // odd MSB position

    // Back-to-back directed stream, checked by the model.
    foreach (vec[i]) begin
      @(posedge clk); #1 bus.iValid = 1'b1; bus.iE = vec[i];
    end
    @(posedge clk); #1 bus.iValid = 1'b0;
    repeat (5) @(posedge clk);

    // Stream with a 2-cycle stall while the first result sits at the output.
    got_q.delete();
    @(posedge clk); #1 bus.iValid = 1'b1; bus.iE = 31'h1000000;
    @(posedge clk); #1 bus.iE = 31'h3000000;
    @(posedge clk); #1 bus.iE = 31'h0800000;
    @(posedge clk); #1 bus.iValid = 1'b0; ce = 1'b0; bus.iE = 31'h7654321;
    @(negedge clk);
    chk("stall_hold_valid", {31'd0, bus.oValid}, 32'd1);
    chk("stall_hold_x",     {6'd0, bus.oX_f},    32'h1000000);
    @(posedge clk); #1 bus.iValid = 1'b1;
    @(negedge clk);
    chk("stall_hold_x2",    {6'd0, bus.oX_f},    32'h1000000);
    @(posedge clk); #1 ce = 1'b1; bus.iValid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_count", got_q.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("stall_order%0d", i),
          (i < got_q.size()) ? {6'd0, got_q[i]} : 32'hFFFFFFFF, {6'd0, stall_exp[i]});

    // Asynchronous reset with two samples still in flight.
    @(posedge clk); #1 bus.iValid = 1'b1; bus.iE = 31'h1000000;
    @(posedge clk); #1 bus.iE = 31'h2000000;
    @(posedge clk); #1 bus.iE = 31'h0000003;
    @(posedge clk); #1 bus.iValid = 1'b0;
    chk("pre_rst_valid", {31'd0, bus.oValid}, 32'd1);
    #1 rst_n = 1'b0; bus.iValid = 1'b1; bus.iE = 31'h4000000;
    #1;
    chk("async_rst_valid", {31'd0, bus.oValid}, 32'd0);
    chk("async_rst_exp",   {26'd0, bus.oExp_f}, 32'd0);
    chk("async_rst_x",     {6'd0, bus.oX_f},    32'd0);
    chk("async_rst_zero",  {31'd0, bus.oZero},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; bus.iValid = 1'b0;
    repeat (4) @(posedge clk);
    lit(31'h1000000, 6'd25, 26'h1000000, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
